// File: rtl/instr_encoder_if.sv
// instr_encoder_if: tuple input channel and instruction-memory write channel
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [15:0]       in_imm16;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm16, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm16, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs field tuples into 32-bit words and streams them into instruction memory
module instr_encoder #(
  parameter int          DEPTH      = 4,
  parameter int          ADDR_W     = 8,
  parameter logic [15:0] LEGAL_MASK = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              mem_full,
  output logic              illegal_err
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
  state_t            state_q, state_d;
  logic [31:0]       fifo_q [DEPTH];
  logic [PW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d, ill_q, ill_d;
  logic              empty, fifo_full, take, legal, push, pop;
  assign empty          = wptr_q == rptr_q;
  assign fifo_full      = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign bus.in_ready   = (state_q == RUN) && !fifo_full && !start;
  assign bus.imem_we    = (state_q == RUN) && !empty && !start;
  assign take           = bus.in_valid && bus.in_ready;
  assign legal          = LEGAL_MASK[bus.in_opcode];
  assign push           = take && legal;
  assign pop            = bus.imem_we && bus.imem_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = fifo_q[rptr_q[PW-1:0]];
  assign word_count     = cnt_q;
  assign busy           = !empty;
  assign mem_full       = full_q;
  assign illegal_err    = ill_q;
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    ill_d   = ill_q;
    if (start) begin
      state_d = RUN;
      wptr_d  = '0;
      rptr_d  = '0;
      addr_d  = base_addr;
      cnt_d   = '0;
      full_d  = 1'b0;
      ill_d   = 1'b0;
    end else begin
      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      ill_d  = ill_q || (take && !legal);
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q[ADDR_W] ? cnt_q : cnt_q + 1'b1;
        // the top address is the last slot; remaining entries stay queued
        full_d  = full_q || (&addr_q);
        state_d = (&addr_q) ? FULL : state_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ill_q   <= ill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= {bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm16};
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a queue scoreboard checked by an independent write monitor
module tb_instr_encoder;
  localparam int ADDR_W = 8;
  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy, mem_full, illegal_err;
  int                tests = 0, fails = 0;
  logic [39:0]       sb [$];
  logic [ADDR_W-1:0] exp_addr;
  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .LEGAL_MASK(16'h7FFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
    .word_count(word_count), .busy(busy), .mem_full(mem_full), .illegal_err(illegal_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.imem_we && bus.imem_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        logic [39:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e[39:32]));
        chk("wr_data", bus.imem_wdata, e[31:0]);
      end
    end
  end
  task automatic push(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [15:0] imm, input logic [31:0] exp_w, input bit exp_wr);
    bit ok = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm16  = imm;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
    if (ok && exp_wr) begin
      sb.push_back({exp_addr, exp_w});
      exp_addr++;
    end
  endtask
  task automatic do_start(input logic [ADDR_W-1:0] b);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    chk("start_in_ready", 32'(bus.in_ready), 32'd0);
    chk("start_we", 32'(bus.imem_we), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.delete();
    exp_addr = b;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    exp_addr = '0;
    bus.in_valid = 1'b0;
    bus.imem_ready = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(mem_full), 32'd0);
    chk("rst_ill", 32'(illegal_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // basic encode
    do_start(8'h10);
    bus.imem_ready = 1'b1;
    push(4'h8, 4'h3, 4'h1, 4'h2, 16'h00AB, 32'h831200AB, 1);
    @(negedge clk);
    chk("t1_we", 32'(bus.imem_we), 32'd1);
    @(negedge clk);
    chk("t1_count", 32'(word_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    // backpressure
    do_start(8'h10);
    bus.imem_ready = 1'b0;
    push(4'h1, 4'h1, 4'h2, 4'h3, 16'h0001, 32'h11230001, 1);
    push(4'h2, 4'h4, 4'h5, 4'h6, 16'h0102, 32'h24560102, 1);
    push(4'h3, 4'h7, 4'h8, 4'h9, 16'h0203, 32'h37890203, 1);
    push(4'h4, 4'hA, 4'hB, 4'hC, 16'h0304, 32'h4ABC0304, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_we", 32'(bus.imem_we), 32'd1);
      chk("bp_addr", 32'(bus.imem_addr), 32'h10);
      chk("bp_data", bus.imem_wdata, 32'h11230001);
    end
    @(posedge clk);
    #1;
    bus.imem_ready = 1'b1;
    push(4'h5, 4'hD, 4'hE, 4'hF, 16'h0405, 32'h5DEF0405, 1);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
    chk("bp_count", 32'(word_count), 32'd5);
    chk("bp_drained", 32'(busy), 32'd0);
    // illegal opcode dropped
    do_start(8'h20);
    push(4'hF, 4'h1, 4'h1, 4'h1, 16'h0000, 32'h0, 0);
    @(negedge clk);
    chk("ill_flag", 32'(illegal_err), 32'd1);
    chk("ill_we", 32'(bus.imem_we), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    push(4'h1, 4'h2, 4'h3, 4'h4, 16'h1234, 32'h12341234, 1);
    repeat (2) @(negedge clk);
    chk("ill_count", 32'(word_count), 32'd1);
    chk("ill_sticky", 32'(illegal_err), 32'd1);
    // wrap at top address
    @(posedge clk);
    #1;
    do_start(8'hFE);
    push(4'h2, 4'h5, 4'h6, 4'h7, 16'h0001, 32'h25670001, 1);
    push(4'h3, 4'h8, 4'h9, 4'hA, 16'hBEEF, 32'h389ABEEF, 1);
    push(4'h4, 4'h1, 4'h1, 4'h1, 16'hFFFF, 32'h4111FFFF, 0);
    repeat (2) @(negedge clk);
    chk("wrap_full", 32'(mem_full), 32'd1);
    chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
    chk("wrap_count", 32'(word_count), 32'd2);
    chk("wrap_busy", 32'(busy), 32'd1);
    chk("wrap_in_ready", 32'(bus.in_ready), 32'd0);
    chk("wrap_we", 32'(bus.imem_we), 32'd0);
    chk("wrap_ill_cleared", 32'(illegal_err), 32'd0);
    // restart from FULL with a tuple offered
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_opcode = 4'h6;
    do_start(8'h30);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_full", 32'(mem_full), 32'd0);
    chk("rs_ill", 32'(illegal_err), 32'd0);
    chk("rs_addr", 32'(bus.imem_addr), 32'h30);
    chk("rs_count", 32'(word_count), 32'd0);
    chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
    // reset mid-stream
    @(posedge clk);
    #1;
    bus.imem_ready = 1'b0;
    push(4'h7, 4'h1, 4'h2, 4'h3, 16'h5555, 32'h0, 0);
    push(4'h8, 4'h4, 4'h5, 4'h6, 16'hAAAA, 32'h0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_we", 32'(bus.imem_we), 32'd0);
    chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mr_addr", 32'(bus.imem_addr), 32'd0);
    chk("mr_count", 32'(word_count), 32'd0);
    bus.imem_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mr_idle_we", 32'(bus.imem_we), 32'd0);
    bus.in_valid = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Turns per-field instruction tuples (opcode, rd, rs1, rs2, imm16) into packed 32-bit instruction words.
- Field layout is identical to the core's instruction format, so every word it writes decodes back to the same fields.
- Buffers words in a small FIFO and drains them to the instruction-memory write port under a valid/ready handshake, with an auto-incrementing address.
- Used by the program loader to fill instruction memory before the core runs.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- ADDR_W, 8, instruction-memory address width
- LEGAL_MASK, 16'hFFFF, bit n=1 means opcode n is legal

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: begin/restart a load session at base_addr
- base_addr  input  ADDR_W  first write address, sampled on start
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple
- in_opcode  input  4  opcode field
- in_rd  input  4  destination register
- in_rs1  input  4  source register 1
- in_rs2  input  4  source register 2
- in_imm16  input  16  immediate
- imem_we  output  1  write request (valid)
- imem_ready  input  1  memory accepts write this cycle
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  32  encoded word
- word_count  output  ADDR_W+1  words written this session
- busy  output  1  FIFO non-empty
- mem_full  output  1  sticky: top address written, session halted
- illegal_err  output  1  sticky: an illegal opcode was dropped

Behaviour:
- Encoding: wdata = {opcode, rd, rs1, rs2, imm16}, mapped to bits [31:28], [27:24], [23:20], [19:16], [15:0]. Pure bit packing, no arithmetic.
- FSM states:
  - IDLE (after reset): in_ready=0, imem_we=0.
  - RUN: normal operation.
  - FULL: reached after the write to address 2^ADDR_W-1; in_ready=0, imem_we=0.
  - start in any state -> RUN.
- Reset (rst_n=0 at clk edge): state IDLE, FIFO empty, imem_addr=0, word_count=0, mem_full=0, illegal_err=0, busy=0, imem_we=0. imem_wdata is don't-care while imem_we=0. Reset mid-session discards all FIFO contents.
- start:
  - Flushes the FIFO, sets imem_addr=base_addr, clears word_count, mem_full and illegal_err, enters RUN.
  - Has priority: in its cycle in_ready=0 and imem_we=0, so no handshake completes.
- Input handshake:
  - in_ready = (state==RUN) && FIFO not full && !start.
  - A transfer occurs when in_valid && in_ready.
  - in_ready does not depend on a same-cycle pop, so there is no push while full.
- Illegal opcode (LEGAL_MASK[opcode]==0): handshake completes, tuple is dropped (not pushed), illegal_err is set next cycle and stays set until start or reset.
- Latency: an accepted legal tuple appears at imem_wdata with imem_we=1 on the next cycle at the earliest.
- Output handshake:
  - imem_we = (state==RUN) && FIFO non-empty && !start.
  - imem_addr and imem_wdata are held stable while imem_we && !imem_ready.
  - On imem_we && imem_ready: pop the FIFO, imem_addr+1, word_count+1.
- Simultaneous push and pop in one cycle is allowed; occupancy is unchanged.
- Wrap-around: a write accepted at address 2^ADDR_W-1 sets mem_full, wraps imem_addr to 0 and enters FULL. Any remaining FIFO entries are held, not written. Only start or reset leaves FULL.
- word_count saturates at 2^ADDR_W.
- busy = FIFO non-empty, in every state.

Test Plan:
- Reset, start with base_addr=0x10; push opcode=8, rd=3, rs1=1, rs2=2, imm=0x00AB with imem_ready=1 -> next cycle imem_we=1, addr=0x10, wdata=0x831200AB; then word_count=1, busy=0.
- Backpressure: hold imem_ready=0 and push 5 tuples -> in_ready drops after 4 (DEPTH); wdata/addr stay stable. Release imem_ready -> words written in order to 0x10..0x14, word_count=5.
- Illegal opcode: with LEGAL_MASK=16'h7FFF, push opcode=0xF -> handshake completes, no write, illegal_err=1. Then a legal push writes normally and illegal_err stays 1 until start.
- Wrap: start at base_addr=0xFE, push 3 tuples -> writes at 0xFE and 0xFF only. mem_full=1, state FULL, imem_addr=0, word_count=2, third word held (busy=1), in_ready=0.
- start while FULL with busy=1 and in_valid=1 -> that cycle no handshake and imem_we=0. Next cycle: FIFO empty, mem_full=0, illegal_err=0, addr=base_addr, word_count=0.
- Reset mid-stream (rst_n low one cycle with 2 words queued) -> IDLE, all outputs 0, in_ready=0 until the next start.
